mem_access_arbiter: RTL

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: fixed-priority arbiter sharing one memory port between
// instruction fetches and load/store operands, with a bounded wait timeout.
`default_nettype none

module mem_access_arbiter #(
   parameter int WIDTH    = 5,
   parameter int DWIDTH   = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_req,
   input  logic [WIDTH-1:0]  inst_addr,
   output logic              inst_gnt,
   input  logic              op_req,
   input  logic              op_we,
   input  logic [WIDTH-1:0]  op_addr,
   input  logic [DWIDTH-1:0] op_wdata,
   output logic              op_gnt,
   output logic              rvalid,
   output logic              rsrc,
   output logic [DWIDTH-1:0] rdata,
   output logic              err,
   output logic              sel,
   output logic [WIDTH-1:0]  mem_addr,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INST = 2'd1,
      S_OP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_start_inst;
   logic              w_start_op;
   logic              w_done;
   logic              w_timeout;
   logic              w_src;

   logic [CW-1:0]     r_wait;
   logic              r_inst_gnt;
   logic              r_op_gnt;
   logic              r_rvalid;
   logic              r_rsrc;
   logic [DWIDTH-1:0] r_rdata;
   logic              r_err;
   logic              r_sel;
   logic [WIDTH-1:0]  r_mem_addr;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [DWIDTH-1:0] r_mem_wdata;

   assign w_src = (r_state == S_OP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operand requests take priority; completion beats timeout in the same cycle.
   always_comb begin
      w_next       = r_state;
      w_start_inst = 1'b0;
      w_start_op   = 1'b0;
      w_done       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (op_req) begin
               w_next     = S_OP;
               w_start_op = 1'b1;
            end else if (inst_req) begin
               w_next       = S_INST;
               w_start_inst = 1'b1;
            end
         end
         S_INST, S_OP: begin
            if (mem_ready) begin
               w_next = S_IDLE;
               w_done = 1'b1;
            end else if (r_wait == CW'(MAX_WAIT - 1)) begin
               w_next    = S_IDLE;
               w_timeout = 1'b1;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait      <= '0;
         r_inst_gnt  <= 1'b0;
         r_op_gnt    <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rsrc      <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_sel       <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         r_inst_gnt <= w_start_inst;
         r_op_gnt   <= w_start_op;
         r_rvalid   <= w_done;
         r_err      <= w_timeout;

         if (w_start_op) begin
            r_wait      <= '0;
            r_sel       <= 1'b1;
            r_mem_addr  <= op_addr;
            r_mem_we    <= op_we;
            r_mem_wdata <= op_wdata;
            r_mem_en    <= 1'b1;
         end else if (w_start_inst) begin
            r_wait     <= '0;
            r_sel      <= 1'b0;
            r_mem_addr <= inst_addr;
            r_mem_we   <= 1'b0;
            r_mem_en   <= 1'b1;
         end else if (w_done || w_timeout) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_rsrc   <= w_src;
         end else if (r_state != S_IDLE && r_wait != CW'(MAX_WAIT)) begin
            r_wait <= r_wait + 1'b1;
         end

         if (w_done) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   assign inst_gnt  = r_inst_gnt;
   assign op_gnt    = r_op_gnt;
   assign rvalid    = r_rvalid;
   assign rsrc      = r_rsrc;
   assign rdata     = r_rdata;
   assign err       = r_err;
   assign sel       = r_sel;
   assign mem_addr  = r_mem_addr;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire
